// File: rtl/en_pulse_gen.sv
// en_pulse_gen: enable-triggered pulse generator.
// A rising edge on en (accepted only when idle) starts an optional delay,
// then dout goes high for hi_len cycles. In periodic mode high/low phases
// repeat while en stays high. Timing inputs are captured at the trigger edge.
module en_pulse_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] hi_len,
  input  logic [CNT_W-1:0] lo_len,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             en_d_q;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic             dout_q, busy_q, done_q;
  logic             done_d;

  logic             trigger;
  logic             last;
  logic [CNT_W-1:0] hi_eff;
  logic [CNT_W-1:0] lo_eff;

  // A zero length would otherwise produce an empty phase; clamp it to one cycle.
  assign hi_eff  = (hi_len == '0) ? ONE : hi_len;
  assign lo_eff  = (lo_len == '0) ? ONE : lo_len;
  assign trigger = en & ~en_d_q;
  // The counter holds the cycles remaining in the current phase, so the
  // phase ends on the edge where it would drop below one.
  assign last    = (cnt_q <= ONE);

  // Next-state, counter and latched-config logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          mode_d = mode;
          hi_d   = hi_eff;
          lo_d   = lo_eff;
          if (dly == '0) begin
            state_d = HIGH;
            cnt_d   = hi_eff;
          end else begin
            state_d = DELAY;
            cnt_d   = dly;
          end
        end
      end

      DELAY: begin
        // Dropping en during the delay aborts silently: no pulse, no done.
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = HIGH;
          cnt_d   = hi_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      HIGH: begin
        // The high phase always runs to completion; en is only looked at
        // when deciding what follows it.
        if (last) begin
          if (!mode_q || !en) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = lo_q;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      LOW: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (last) begin
          state_d = HIGH;
          cnt_d   = hi_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, edge-detect register and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and wins over everything, including an
    // in-flight sequence; no done strobe is produced by a reset.
    if (!aresetn) begin
      state_q <= IDLE;
      en_d_q  <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      en_d_q  <= en;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dout_q  <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_en_pulse_gen.sv
// Directed self-checking bench for en_pulse_gen.
// Each sequence is described relative to its trigger edge E0: bit k of a
// vector is the en value sampled at E0+k, or the output expected after E0+k.
module tb_en_pulse_gen;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             aresetn;
  logic             en;
  logic             mode;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic             dout;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  en_pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .en     (en),
    .mode   (mode),
    .dly    (dly),
    .hi_len (hi_len),
    .lo_len (lo_len),
    .dout   (dout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_dout, input logic e_busy,
                            input logic e_done);
    check({tag, ".dout"}, dout, e_dout);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".done"}, done, e_done);
  endtask

  // Run n edges starting at E0. When scramble is set, every timing input is
  // changed right after E0 to values that would visibly alter the pulse if
  // they were not held from the trigger edge.
  task automatic seq(input string tag, input int n, input logic [31:0] en_v,
                     input logic [31:0] dout_v, input logic [31:0] busy_v,
                     input logic [31:0] done_v, input bit scramble);
    for (int k = 0; k < n; k++) begin
      en = en_v[k];
      tick();
      check_outs($sformatf("%s@E0+%0d", tag, k), dout_v[k], busy_v[k], done_v[k]);
      if (k == 0 && scramble) begin
        mode   = 1'b1;
        dly    = 8'd7;
        hi_len = 8'd9;
        lo_len = 8'd1;
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    dly     = '0;
    hi_len  = '0;
    lo_len  = '0;

    // Reset state.
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0);

    // One-shot, dly=3, hi_len=4: dout E0+3..E0+6, busy E0..E0+6, done E0+7.
    mode = 1'b0; dly = 8'd3; hi_len = 8'd4; lo_len = 8'd2;
    seq("oneshot", 10, 32'h3FF, 32'h078, 32'h07F, 32'h080, 1'b1);
    en = 1'b0;
    tick();
    check_outs("oneshot.after", 1'b0, 1'b0, 1'b0);

    // Periodic, dly=0, hi=2, lo=3, en first sampled 0 at E0+11.
    mode = 1'b1; dly = 8'd0; hi_len = 8'd2; lo_len = 8'd3;
    seq("periodic", 14, 32'h7FF, 32'hC63, 32'hFFF, 32'h1000, 1'b0);

    // Abort during the delay: en sampled 0 at E0+4, no pulse, no done.
    mode = 1'b0; dly = 8'd10; hi_len = 8'd5;
    seq("abort", 16, 32'h00F, 32'h0, 32'h00F, 32'h0, 1'b0);

    // Zero lengths: one-cycle pulse, then no retrigger while en stays high.
    mode = 1'b0; dly = 8'd0; hi_len = 8'd0;
    seq("zero", 22, 32'h3FFFFF, 32'h1, 32'h1, 32'h2, 1'b0);
    en = 1'b0;
    tick();
    check_outs("zero.gap", 1'b0, 1'b0, 1'b0);
    seq("zero.re", 4, 32'hF, 32'h1, 32'h1, 32'h2, 1'b0);
    en = 1'b0;
    tick();

    // Reset in the middle of the high phase with en held high.
    mode = 1'b0; dly = 8'd2; hi_len = 8'd8;
    seq("rst.pre", 5, 32'h1F, 32'h1C, 32'h1F, 32'h0, 1'b0);
    aresetn = 1'b0;
    en      = 1'b1;
    tick();
    check_outs("rst.edge", 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    // en_d was cleared, so the very next edge is a fresh trigger.
    seq("rst.post", 12, 32'hFFF, 32'h3FC, 32'h3FF, 32'h400, 1'b0);
    en = 1'b0;
    tick();

    // en toggling during the high phase plus changed timing after E0:
    // single pulse E0+2..E0+4 with the latched values, extra edge ignored.
    mode = 1'b0; dly = 8'd2; hi_len = 8'd3; lo_len = 8'd4;
    seq("toggle", 9, 32'h17, 32'h1C, 32'h1F, 32'h20, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
